// File: rtl/if_id_buffer.sv
// ============================================================================
//  Module      : if_id_buffer
//  Description : IF/ID pipeline register with B-type branch pre-decode.
//                Pairs each returning instruction word with its fetch address,
//                drops wrong-path words after flushes and redirects, and feeds
//                ID_branch / imme / ID_kick_up back to IF.
//                Optional performance counters: define IF_ID_PERF_CNT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module if_id_buffer #(
  parameter int unsigned XLEN          = 32,
  parameter logic [6:0]  BRANCH_OPCODE = 7'b1100011
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] inst_mem_read_addr,
  input  logic [XLEN-1:0] inst_mem_read_data,
  input  logic            EX_stall,
  input  logic            EX_flush,
  input  logic            IF_kick_up,
  output logic [XLEN-1:0] ID_inst,
  output logic [XLEN-1:0] ID_pc,
  output logic            ID_valid,
  output logic            ID_branch,
  output logic [XLEN-1:0] imme,
  output logic            ID_kick_up,
  output logic [31:0]     branch_count,
  output logic [31:0]     squash_count
);

  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] inst_q, inst_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            valid_q, valid_d;
  logic            kill_q, kill_d;
  logic            issued_q, issued_d;
  logic            kick_q, kick_d;

  logic            w_capture;
  logic            w_branch_accept;
  logic            w_squash;

  // Pre-decode of the held word and the cycle qualifiers for the update logic
  always_comb begin
    ID_branch       = valid_q && (inst_q[6:0] == BRANCH_OPCODE) && !issued_q;
    imme            = {{(XLEN-12){inst_q[31]}}, inst_q[7], inst_q[30:25],
                       inst_q[11:8], 1'b0};
    w_capture       = !EX_stall && !EX_flush;
    w_branch_accept = ID_branch && w_capture;
    w_squash        = w_capture && kill_q;
  end

  // Next-state: stall holds all, flush discards, otherwise capture the new word
  always_comb begin
    addr_d   = addr_q;
    inst_d   = inst_q;
    pc_d     = pc_q;
    valid_d  = valid_q;
    kill_d   = kill_q;
    issued_d = issued_q;
    kick_d   = kick_q;
    if (!EX_stall) begin
      addr_d = inst_mem_read_addr;
      if (EX_flush) begin
        // Held and in-flight words are both wrong-path
        valid_d = 1'b0;
        kill_d  = 1'b1;
        kick_d  = 1'b1;
      end else begin
        inst_d  = inst_mem_read_data;
        pc_d    = addr_q;
        valid_d = !kill_q;
        // A redirect makes the word presented this cycle wrong-path; a
        // consumed kill clears when no redirect re-arms it
        kill_d  = ID_branch;
        // Set wins over the capture-clear so the word captured alongside an
        // accepted branch can never raise a second redirect
        issued_d = ID_branch;
        if (!kill_q) begin
          kick_d = 1'b0;
        end
      end
    end
    if (IF_kick_up) begin
      kick_d = 1'b1;
    end
  end

  // Pipeline state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q   <= '0;
      inst_q   <= '0;
      pc_q     <= '0;
      valid_q  <= 1'b0;
      kill_q   <= 1'b1;   // memory output in the reset cycle is undefined
      issued_q <= 1'b0;
      kick_q   <= 1'b1;
    end else begin
      addr_q   <= addr_d;
      inst_q   <= inst_d;
      pc_q     <= pc_d;
      valid_q  <= valid_d;
      kill_q   <= kill_d;
      issued_q <= issued_d;
      kick_q   <= kick_d;
    end
  end

  assign ID_inst    = inst_q;
  assign ID_pc      = pc_q;
  assign ID_valid   = valid_q;
  assign ID_kick_up = kick_q;

`ifdef IF_ID_PERF_CNT_EN
  logic [31:0] branch_count_q, branch_count_d;
  logic [31:0] squash_count_q, squash_count_d;

  // Event counters; natural 32-bit wrap
  always_comb begin
    branch_count_d = branch_count_q;
    squash_count_d = squash_count_q;
    if (w_branch_accept) begin
      branch_count_d = branch_count_q + 32'd1;
    end
    if (w_squash) begin
      squash_count_d = squash_count_q + 32'd1;
    end
  end

  // Counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      branch_count_q <= '0;
      squash_count_q <= '0;
    end else begin
      branch_count_q <= branch_count_d;
      squash_count_q <= squash_count_d;
    end
  end

  assign branch_count = branch_count_q;
  assign squash_count = squash_count_q;
`else
  logic w_unused_perf;
  assign w_unused_perf = w_branch_accept ^ w_squash;
  assign branch_count  = '0;
  assign squash_count  = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_if_id_buffer.sv
// ============================================================================
//  Module      : tb_if_id_buffer
//  Description : Directed self-checking bench for if_id_buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_if_id_buffer;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] BEQ = 32'hFE00_0EE3;
`ifdef IF_ID_PERF_CNT_EN
  localparam int unsigned PERF = 1;
`else
  localparam int unsigned PERF = 0;
`endif

  logic        clk;
  logic        reset;
  logic [31:0] addr;
  logic [31:0] data;
  logic        stall;
  logic        flush;
  logic        kick_in;
  logic [31:0] id_inst;
  logic [31:0] id_pc;
  logic        id_valid;
  logic        id_branch;
  logic [31:0] imme;
  logic        id_kick;
  logic [31:0] br_cnt;
  logic [31:0] sq_cnt;

  int errors = 0;
  int checks = 0;

  if_id_buffer dut (
    .clk                (clk),
    .reset              (reset),
    .inst_mem_read_addr (addr),
    .inst_mem_read_data (data),
    .EX_stall           (stall),
    .EX_flush           (flush),
    .IF_kick_up         (kick_in),
    .ID_inst            (id_inst),
    .ID_pc              (id_pc),
    .ID_valid           (id_valid),
    .ID_branch          (id_branch),
    .imme               (imme),
    .ID_kick_up         (id_kick),
    .branch_count       (br_cnt),
    .squash_count       (sq_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock: drive inputs, take the edge, settle 1 time unit past it
  task automatic cyc(input logic [31:0] a, input logic [31:0] d,
                     input logic st, input logic fl, input logic rs);
    addr  = a;
    data  = d;
    stall = st;
    flush = fl;
    reset = rs;
    @(posedge clk);
    #1;
    reset   = 1'b0;
    kick_in = 1'b0;
  endtask

  task automatic test_reset;
    cyc(32'h0, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b1);
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", id_valid); end
    checks++; if (id_inst !== 32'h0) begin errors++; $display("FAIL rst_inst: got %h want 0", id_inst); end
    checks++; if (id_pc !== 32'h0) begin errors++; $display("FAIL rst_pc: got %h want 0", id_pc); end
    checks++; if (id_branch !== 1'b0) begin errors++; $display("FAIL rst_branch: got %b want 0", id_branch); end
    checks++; if (imme !== 32'h0) begin errors++; $display("FAIL rst_imme: got %h want 0", imme); end
    checks++; if (id_kick !== 1'b1) begin errors++; $display("FAIL rst_kick: got %b want 1", id_kick); end
    checks++; if (br_cnt !== 32'h0 || sq_cnt !== 32'h0) begin errors++; $display("FAIL rst_cnt: got %h/%h want 0/0", br_cnt, sq_cnt); end
  endtask

  // Addresses 0,4,8: word 0 dropped, word 4 valid two cycles after address 4
  task automatic test_fill;
    test_reset();
    cyc(32'h4, 32'hBAD0_BAD0, 1'b0, 1'b0, 1'b0);
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL fill_drop: valid %b want 0", id_valid); end
    checks++; if (id_kick !== 1'b1) begin errors++; $display("FAIL fill_kick_hold: got %b want 1", id_kick); end
    checks++; if (sq_cnt !== PERF) begin errors++; $display("FAIL fill_sqcnt: got %0d want %0d", sq_cnt, PERF); end
    cyc(32'h8, NOP, 1'b0, 1'b0, 1'b0);
    checks++; if (id_valid !== 1'b1 || id_pc !== 32'h4 || id_inst !== NOP) begin
      errors++; $display("FAIL fill_cap: valid %b pc %h inst %h want 1 4 %h", id_valid, id_pc, id_inst, NOP); end
    checks++; if (id_kick !== 1'b0) begin errors++; $display("FAIL fill_kick_fall: got %b want 0", id_kick); end
    checks++; if (id_branch !== 1'b0) begin errors++; $display("FAIL fill_nobranch: got %b want 0", id_branch); end
  endtask

  task automatic test_branch;
    cyc(32'h1C, 32'h0, 1'b0, 1'b0, 1'b1);
    cyc(32'h20, 32'hBAD0_BAD0, 1'b0, 1'b0, 1'b0);
    cyc(32'h24, BEQ, 1'b0, 1'b0, 1'b0);
    checks++; if (id_branch !== 1'b1 || id_pc !== 32'h20) begin
      errors++; $display("FAIL br_assert: branch %b pc %h want 1 20", id_branch, id_pc); end
    checks++; if (imme !== 32'hFFFF_FFFC) begin errors++; $display("FAIL br_imme: got %h want fffffffc", imme); end
    cyc(32'h28, NOP, 1'b0, 1'b0, 1'b0);
    checks++; if (id_branch !== 1'b0 || id_valid !== 1'b1 || id_pc !== 32'h24) begin
      errors++; $display("FAIL br_oneshot: branch %b valid %b pc %h want 0 1 24", id_branch, id_valid, id_pc); end
    // Back-to-back: a second branch at 0x28 is the squashed word
    cyc(32'h2C, BEQ, 1'b0, 1'b0, 1'b0);
    checks++; if (id_valid !== 1'b0 || id_branch !== 1'b0) begin
      errors++; $display("FAIL br_b2b_drop: valid %b branch %b want 0 0", id_valid, id_branch); end
    cyc(32'h30, NOP, 1'b0, 1'b0, 1'b0);
    checks++; if (id_valid !== 1'b1 || id_pc !== 32'h2C) begin
      errors++; $display("FAIL br_resume: valid %b pc %h want 1 2c", id_valid, id_pc); end
    checks++; if (br_cnt !== PERF || sq_cnt !== 2 * PERF) begin
      errors++; $display("FAIL br_cnt: br %0d sq %0d want %0d %0d", br_cnt, sq_cnt, PERF, 2 * PERF); end
  endtask

  task automatic test_branch_stall;
    cyc(32'h1C, 32'h0, 1'b0, 1'b0, 1'b1);
    cyc(32'h20, 32'hBAD0_BAD0, 1'b0, 1'b0, 1'b0);
    cyc(32'h24, BEQ, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc(32'h28, NOP, 1'b1, 1'b0, 1'b0);
      checks++; if (id_branch !== 1'b1 || id_valid !== 1'b1 || id_pc !== 32'h20 || id_inst !== BEQ) begin
        errors++; $display("FAIL stall_hold%0d: br %b v %b pc %h inst %h", i, id_branch, id_valid, id_pc, id_inst); end
    end
    cyc(32'h28, NOP, 1'b0, 1'b0, 1'b0);
    checks++; if (id_branch !== 1'b0 || id_pc !== 32'h24 || id_valid !== 1'b1) begin
      errors++; $display("FAIL stall_release: br %b pc %h v %b want 0 24 1", id_branch, id_pc, id_valid); end
    cyc(32'h2C, NOP, 1'b0, 1'b0, 1'b0);
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL stall_drop: valid %b want 0", id_valid); end
    checks++; if (br_cnt !== PERF) begin errors++; $display("FAIL stall_brcnt: got %0d want %0d", br_cnt, PERF); end
  endtask

  task automatic test_flush;
    test_fill();
    cyc(32'hC, NOP, 1'b0, 1'b1, 1'b0);
    checks++; if (id_valid !== 1'b0 || id_kick !== 1'b1) begin
      errors++; $display("FAIL flush_apply: valid %b kick %b want 0 1", id_valid, id_kick); end
    cyc(32'h10, NOP, 1'b0, 1'b0, 1'b0);
    checks++; if (id_valid !== 1'b0 || id_kick !== 1'b1) begin
      errors++; $display("FAIL flush_drop: valid %b kick %b want 0 1", id_valid, id_kick); end
    cyc(32'h14, NOP, 1'b0, 1'b0, 1'b0);
    checks++; if (id_valid !== 1'b1 || id_pc !== 32'h10 || id_kick !== 1'b0) begin
      errors++; $display("FAIL flush_resume: valid %b pc %h kick %b want 1 10 0", id_valid, id_pc, id_kick); end
  endtask

  task automatic test_stall_flush;
    test_fill();
    cyc(32'hC, 32'h1234_5678, 1'b1, 1'b1, 1'b0);
    checks++; if (id_valid !== 1'b1 || id_pc !== 32'h4 || id_inst !== NOP || id_kick !== 1'b0) begin
      errors++; $display("FAIL sf_ignore: v %b pc %h inst %h kick %b", id_valid, id_pc, id_inst, id_kick); end
    cyc(32'hC, NOP, 1'b0, 1'b1, 1'b0);
    checks++; if (id_valid !== 1'b0 || id_kick !== 1'b1) begin
      errors++; $display("FAIL sf_flush: valid %b kick %b want 0 1", id_valid, id_kick); end
  endtask

  task automatic test_kick_and_reset_stall;
    test_fill();
    kick_in = 1'b1;
    cyc(32'hC, NOP, 1'b0, 1'b0, 1'b0);
    checks++; if (id_kick !== 1'b1 || id_valid !== 1'b1 || id_pc !== 32'h8) begin
      errors++; $display("FAIL kick_set: kick %b v %b pc %h want 1 1 8", id_kick, id_valid, id_pc); end
    cyc(32'h10, NOP, 1'b0, 1'b0, 1'b0);
    checks++; if (id_kick !== 1'b0) begin errors++; $display("FAIL kick_clear: got %b want 0", id_kick); end
    cyc(32'h14, NOP, 1'b1, 1'b0, 1'b1);
    checks++; if (id_valid !== 1'b0 || id_pc !== 32'h0 || id_kick !== 1'b1) begin
      errors++; $display("FAIL rst_in_stall: v %b pc %h kick %b want 0 0 1", id_valid, id_pc, id_kick); end
  endtask

`ifdef IF_ID_PERF_CNT_EN
  task automatic test_squash_wrap;
    cyc(32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    force dut.squash_count_q = 32'hFFFF_FFFF;
    #1;
    release dut.squash_count_q;
    cyc(32'h4, NOP, 1'b0, 1'b0, 1'b0);
    checks++; if (sq_cnt !== 32'h0) begin errors++; $display("FAIL sq_wrap: got %h want 0", sq_cnt); end
  endtask
`endif

  initial begin
    reset = 1'b1; addr = '0; data = '0; stall = 1'b0; flush = 1'b0; kick_in = 1'b0;
    test_reset();
    test_fill();
    test_branch();
    test_branch_stall();
    test_flush();
    test_stall_flush();
    test_kick_and_reset_stall();
`ifdef IF_ID_PERF_CNT_EN
    test_squash_wrap();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
